// File: rtl/opendap_dp_ap_engine.sv
// ---------------------------------------------------------------------------
// opendap_dp_ap_engine
//
// AP transaction engine for the SW-DP. Turns each accepted AP host access into
// one req/ack transaction on the access port chosen by SELECT.APSEL. Reads are
// posted: the host always sees RDBUFF, which holds the result of the previous
// completed read. Adds multi-AP demux, out-of-range APSEL errors, a response
// timeout and DAPABORT cancellation on top of the single-AP behaviour.
//
// Ports:
//   swclk, rst          clock, synchronous active-high reset
//   host_en             one-cycle AP access strobe from serial comms
//   host_r_nw           1 = read, 0 = write
//   host_addr           A[3:2] of the AP register
//   host_wdata          write data
//   host_rdata          RDBUFF (last completed read result)
//   host_busy           transaction outstanding (comms answers WAIT)
//   select_apsel        SELECT.APSEL, picks the AP channel
//   select_apbanksel    SELECT.APBANKSEL, upper AP address bits
//   orundetect          CTRL/STAT.ORUNDETECT
//   dap_abort           ABORT.DAPABORT strobe
//   set_stickyerr       one-cycle pulse to set STICKYERR
//   set_stickyorun      one-cycle pulse to set STICKYORUN
//   ap_req              one-hot request to the AP channels
//   ap_addr             {apbanksel, host_addr}
//   ap_wen, ap_wdata    write enable and data for the request
//   ap_rdata            read data, channel i at [32i+31:32i]
//   ap_ack, ap_err      per-channel completion and error (err valid with ack)
//   ap_abort            one-cycle cancel pulse to the selected channel
// ---------------------------------------------------------------------------
module opendap_dp_ap_engine #(
  parameter int N_AP    = 4,
  parameter int APSEL_W = 8,
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic                 swclk,
  input  logic                 rst,
  input  logic                 host_en,
  input  logic                 host_r_nw,
  input  logic [1:0]           host_addr,
  input  logic [31:0]          host_wdata,
  output logic [31:0]          host_rdata,
  output logic                 host_busy,
  input  logic [APSEL_W-1:0]   select_apsel,
  input  logic [3:0]           select_apbanksel,
  input  logic                 orundetect,
  input  logic                 dap_abort,
  output logic                 set_stickyerr,
  output logic                 set_stickyorun,
  output logic [N_AP-1:0]      ap_req,
  output logic [5:0]           ap_addr,
  output logic                 ap_wen,
  output logic [31:0]          ap_wdata,
  input  logic [32*N_AP-1:0]   ap_rdata,
  input  logic [N_AP-1:0]      ap_ack,
  input  logic [N_AP-1:0]      ap_err,
  output logic [N_AP-1:0]      ap_abort
);

  localparam int SEL_W = (N_AP > 1) ? $clog2(N_AP) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // APSEL is compared one bit wider so N_AP = 2^APSEL_W still fits.
  localparam logic [APSEL_W:0] NAP_LIMIT = (APSEL_W+1)'(N_AP);
  localparam logic [TO_W-1:0]  TO_LAST   = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  logic [0:0]        r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [TO_W-1:0]   r_cnt;
  logic [31:0]       r_rdbuff;
  logic [N_AP-1:0]   r_req;
  logic [5:0]        r_addr;
  logic              r_wen;
  logic [31:0]       r_wdata;
  logic              r_stickyerr;
  logic              r_stickyorun;
  logic [N_AP-1:0]   r_abort;

  logic              w_sel_in_range;
  logic [SEL_W-1:0]  w_new_sel;
  logic [31:0]       w_rdata_arr [N_AP];
  logic [31:0]       w_sel_rdata;
  logic              w_sel_ack;
  logic              w_sel_err;
  logic              w_timeout;

  // Split the flat read-data bus into one word per channel.
  for (genvar gi = 0; gi < N_AP; gi++) begin : g_rdata
    assign w_rdata_arr[gi] = ap_rdata[32*gi +: 32];
  end

  assign w_sel_in_range = ({1'b0, select_apsel} < NAP_LIMIT);
  assign w_new_sel      = select_apsel[SEL_W-1:0];

  // Only the latched channel can complete the transaction; acks from other
  // channels never reach the state machine.
  assign w_sel_rdata = w_rdata_arr[r_sel];
  assign w_sel_ack   = ap_ack[r_sel];
  assign w_sel_err   = ap_err[r_sel];

  // A TIMEOUT of zero disables the response timeout entirely.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  // Main transaction FSM. Status pulses default low every cycle so each one
  // lasts exactly one cycle. Within REQ, ack beats dap_abort which beats the
  // timeout, so a late ack is never turned into an error.
  always_ff @(posedge swclk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_cnt        <= '0;
      r_rdbuff     <= '0;
      r_req        <= '0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_stickyerr  <= 1'b0;
      r_stickyorun <= 1'b0;
      r_abort      <= '0;
    end else begin
      r_stickyerr  <= 1'b0;
      r_stickyorun <= 1'b0;
      r_abort      <= '0;
      case (r_state)
        ST_IDLE: begin
          if (host_en) begin
            if (w_sel_in_range) begin
              r_sel            <= w_new_sel;
              r_addr           <= {select_apbanksel, host_addr};
              r_wen            <= ~host_r_nw;
              r_wdata          <= host_wdata;
              r_req            <= '0;
              r_req[w_new_sel] <= 1'b1;
              r_cnt            <= '0;
              r_state          <= ST_REQ;
            end else begin
              // No such AP: flag the error, and a read returns zero.
              r_stickyerr <= 1'b1;
              if (host_r_nw) begin
                r_rdbuff <= '0;
              end
            end
          end
        end
        ST_REQ: begin
          // A second access while busy is dropped; the payload is untouched.
          if (host_en && orundetect) begin
            r_stickyorun <= 1'b1;
          end
          if (w_sel_ack) begin
            r_req   <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            if (!r_wen) begin
              if (w_sel_err) begin
                r_rdbuff    <= '0;
                r_stickyerr <= 1'b1;
              end else begin
                r_rdbuff <= w_sel_rdata;
              end
            end else if (w_sel_err) begin
              r_stickyerr <= 1'b1;
            end
          end else if (dap_abort) begin
            r_req          <= '0;
            r_abort[r_sel] <= 1'b1;
            r_cnt          <= '0;
            r_state        <= ST_IDLE;
          end else if (w_timeout) begin
            r_req          <= '0;
            r_abort[r_sel] <= 1'b1;
            r_stickyerr    <= 1'b1;
            r_cnt          <= '0;
            r_state        <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign host_rdata     = r_rdbuff;
  assign host_busy      = (r_state == ST_REQ);
  assign set_stickyerr  = r_stickyerr;
  assign set_stickyorun = r_stickyorun;
  assign ap_req         = r_req;
  assign ap_addr        = r_addr;
  assign ap_wen         = r_wen;
  assign ap_wdata       = r_wdata;
  assign ap_abort       = r_abort;

endmodule
